chamber_scheduler: RTL
======================

CHAMBER_SCHEDULER -- requirements
Module: chamber_scheduler

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of incubator chambers sharing one temperature sensor.
REQ-002 SHALL have parameter SETTLE, default 3: cycles waited after a mux change before requesting a conversion.
REQ-003 SHALL have parameter TIMEOUT, default 15: maximum cycles sens_req stays high without sens_ack.
REQ-004 SHALL have parameter MAX_HEAT, default 2: maximum heater grants asserted at once.
REQ-005 SHALL have port clk, input, 1: the single clock, all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port sens_sel, output, 2: sensor mux channel select.
REQ-008 SHALL have port sens_req, output, 1: conversion request to the shared sensor.
REQ-009 SHALL have port sens_ack, input, 1: conversion done; sens_data is valid in the same cycle.
REQ-010 SHALL have port sens_data, input, 8: signed two's-complement temperature in degrees C.
REQ-011 SHALL have port ht_req, input, N_CH: per-chamber heater request from each incubator core.
REQ-012 SHALL have port ht_gnt, output, N_CH: per-chamber heater grant.
REQ-013 SHALL have port t_ch, output, 8*N_CH: latest temperature per chamber, with chamber k at bits [8k+7:8k].
REQ-014 SHALL have port t_valid, output, N_CH: set when t_ch slice k holds a fresh sample.
REQ-015 SHALL have port fault, output, N_CH: sticky per-chamber sensor timeout flag.

Function
REQ-016 Poll FSM SHALL use states SEL, SETTLE_W, REQ and NEXT.
REQ-017 SEL: drive sens_sel with the current channel; go to SETTLE_W.
REQ-018 SETTLE_W: count SETTLE cycles; then go to REQ.
REQ-019 REQ: hold sens_req=1 until sens_ack or until TIMEOUT cycles have elapsed.
REQ-020 On ack, SHALL capture sens_data into t_ch[ch], set t_valid[ch]=1 and clear fault[ch] in the same edge; go to NEXT.
REQ-021 On timeout, SHALL set t_valid[ch]=0 and fault[ch]=1, leave t_ch[ch] unchanged, deassert sens_req, and go to NEXT.
REQ-022 If sens_ack and timeout occur in the same cycle, the ack SHALL win.
REQ-023 NEXT: advance the channel modulo N_CH (3 wraps to 0); go to SEL.
REQ-024 sens_req SHALL be high only in REQ; sens_ack outside REQ SHALL be ignored.
REQ-025 Heater arbiter SHALL hold ht_gnt[k] while ht_req[k]=1 and t_valid[k]=1.
REQ-026 ht_gnt[k] SHALL drop one cycle after either ht_req[k] or t_valid[k] falls.
REQ-027 At most one new grant per cycle, only while popcount(ht_gnt) < MAX_HEAT.
REQ-028 Each new grant SHALL go to the first eligible requester round-robin after the last newly granted index.
REQ-029 Eligible requester: ht_req=1, t_valid=1, not already granted.
REQ-030 popcount(ht_gnt) SHALL never exceed MAX_HEAT, including during a same-cycle release and new grant.
REQ-031 A chamber with fault=1 SHALL never be granted heat.
REQ-032 Grant latency from eligible request to ht_gnt SHALL be 1 cycle when capacity is free.

Reset
REQ-033 While rst=0 at a clock edge: state=SEL, channel=0, sens_sel=0, sens_req=0, ht_gnt=0.
REQ-034 While rst=0 at a clock edge: t_ch=0, t_valid=0, fault=0, round-robin pointer=N_CH-1.
REQ-035 Reset asserted mid-conversion SHALL drop sens_req on that edge and discard any ack in that cycle.

Structure
REQ-036 A shared package SHALL hold the poll-state enum, the temperature width (8) and the defaults of N_CH, SETTLE, TIMEOUT and MAX_HEAT.
REQ-037 The round-robin grant logic SHALL be one sub-module, rr_heat_arbiter; the poll FSM and sample registers stay in the top.

Verification
REQ-038 Reset then ack 2 cycles into each REQ, with data 22, -9, 36, 10: t_ch = {10,36,-9,22}, t_valid = 4'b1111, sens_sel sequence 0,1,2,3,0.
REQ-039 No ack on channel 2: sens_req high exactly 15 cycles, then fault[2]=1 and t_valid[2]=0; an ack of 30 on the next poll of channel 2 clears fault[2].
REQ-040 ht_req = 4'b1111 with all samples valid: grants appear one per cycle (0001, then 0011), then stay at 2 bits set.
REQ-041 With 4'b0011 granted, drop ht_req[0]: bit 0 falls and bit 2 is granted in the next cycle, never exceeding 2.
REQ-042 Force a timeout on a granted chamber: its grant drops one cycle after t_valid falls.
REQ-043 rst=0 during REQ with sens_ack also high: next cycle sens_req=0, all outputs zero, polling restarts at channel 0.

Source files
------------

// File: rtl/chamber_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// chamber_scheduler_pkg
// Shared definitions for the incubator chamber scheduler: temperature sample
// width, parameter defaults and the sensor poll-state encoding.
// No ports.
// -----------------------------------------------------------------------------
package chamber_scheduler_pkg;

   localparam int TEMP_W       = 8;
   localparam int N_CH_DEF     = 4;
   localparam int SETTLE_DEF   = 3;
   localparam int TIMEOUT_DEF  = 15;
   localparam int MAX_HEAT_DEF = 2;

   typedef enum logic [1:0] {
      ST_SEL      = 2'd0,
      ST_SETTLE_W = 2'd1,
      ST_REQ      = 2'd2,
      ST_NEXT     = 2'd3
   } poll_state_e;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/chamber_scheduler_rr_heat_arbiter.sv
// -----------------------------------------------------------------------------
// rr_heat_arbiter
// Round-robin heater grant logic. Holds a grant while its chamber keeps
// requesting with a valid, non-faulted sample; issues at most one new grant
// per cycle and only while fewer than MAX_HEAT grants are outstanding.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-low reset
//   ht_req   in   [N_CH] heater request per chamber
//   t_valid  in   [N_CH] fresh temperature sample per chamber
//   fault    in   [N_CH] sticky sensor timeout per chamber
//   ht_gnt   out  [N_CH] heater grant per chamber (registered)
// -----------------------------------------------------------------------------
module rr_heat_arbiter
   import chamber_scheduler_pkg::*;
#(
   parameter int N_CH     = N_CH_DEF,
   parameter int MAX_HEAT = MAX_HEAT_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] ht_req,
   input  logic [N_CH-1:0] t_valid,
   input  logic [N_CH-1:0] fault,
   output logic [N_CH-1:0] ht_gnt
);

   localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int CW = $clog2(N_CH + 1);

   logic [N_CH-1:0] gnt_q, gnt_d;
   logic [PW-1:0]   last_q, last_d;
   logic [N_CH-1:0] eligible;
   logic [CW-1:0]   n_gnt;
   logic [PW:0]     sum;
   logic [PW-1:0]   pick;
   logic            found;

   always_comb begin
      eligible = ht_req & t_valid & ~fault & ~gnt_q;
      gnt_d    = gnt_q & ht_req & t_valid & ~fault;
      last_d   = last_q;
      found    = 1'b0;
      sum      = '0;
      pick     = '0;
      n_gnt    = '0;
      for (int k = 0; k < N_CH; k++) begin
         n_gnt = n_gnt + CW'(gnt_q[k]);
      end
      // Capacity is judged on the grants currently driven, so a release and a
      // new grant in the same cycle can never overshoot MAX_HEAT.
      if (n_gnt < CW'(MAX_HEAT)) begin
         for (int off = 1; off <= N_CH; off++) begin
            sum = {1'b0, last_q} + (PW+1)'(off);
            if (sum >= (PW+1)'(N_CH)) begin
               sum = sum - (PW+1)'(N_CH);
            end
            pick = sum[PW-1:0];
            if (!found && eligible[pick]) begin
               found       = 1'b1;
               gnt_d[pick] = 1'b1;
               last_d      = pick;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         gnt_q  <= '0;
         last_q <= PW'(N_CH - 1);
      end else begin
         gnt_q  <= gnt_d;
         last_q <= last_d;
      end
   end

   assign ht_gnt = gnt_q;

endmodule

// File: rtl/chamber_scheduler.sv
// -----------------------------------------------------------------------------
// chamber_scheduler
// Polls one shared temperature sensor across N_CH incubator chambers and
// arbitrates a limited number of heater grants among them.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   SEL      | present current channel on sens_sel, load settle timer
//   SETTLE_W | wait SETTLE cycles for the analog mux to settle
//   REQ      | sens_req high until ack (capture) or TIMEOUT (fault)
//   NEXT     | advance channel modulo N_CH
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-low reset
//   sens_sel   out  [2] sensor mux select
//   sens_req   out  conversion request (high only in REQ)
//   sens_ack   in   conversion done, sens_data valid this cycle
//   sens_data  in   [8] signed temperature, degrees C
//   ht_req     in   [N_CH] heater request per chamber
//   ht_gnt     out  [N_CH] heater grant per chamber
//   t_ch       out  [8*N_CH] latest temperature, chamber k at [8k+7:8k]
//   t_valid    out  [N_CH] slice k holds a fresh sample
//   fault      out  [N_CH] sticky sensor timeout
// -----------------------------------------------------------------------------
module chamber_scheduler
   import chamber_scheduler_pkg::*;
#(
   parameter int N_CH     = N_CH_DEF,
   parameter int SETTLE   = SETTLE_DEF,
   parameter int TIMEOUT  = TIMEOUT_DEF,
   parameter int MAX_HEAT = MAX_HEAT_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic [1:0]               sens_sel,
   output logic                     sens_req,
   input  logic                     sens_ack,
   input  logic [TEMP_W-1:0]        sens_data,
   input  logic [N_CH-1:0]          ht_req,
   output logic [N_CH-1:0]          ht_gnt,
   output logic [TEMP_W*N_CH-1:0]   t_ch,
   output logic [N_CH-1:0]          t_valid,
   output logic [N_CH-1:0]          fault
);

   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int TMR_W = $clog2(max2(SETTLE, TIMEOUT) + 1);

   localparam logic [1:0] SEL      = ST_SEL;
   localparam logic [1:0] SETTLE_W = ST_SETTLE_W;
   localparam logic [1:0] REQ      = ST_REQ;
   localparam logic [1:0] NEXT     = ST_NEXT;

   logic [1:0]        state_q, state_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [TEMP_W-1:0] t_ch_q [N_CH];
   logic [TEMP_W-1:0] t_ch_d [N_CH];
   logic [N_CH-1:0]   t_valid_q, t_valid_d;
   logic [N_CH-1:0]   fault_q, fault_d;

   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      tmr_d     = tmr_q;
      t_ch_d    = t_ch_q;
      t_valid_d = t_valid_q;
      fault_d   = fault_q;
      case (state_q)
         SEL: begin
            tmr_d   = TMR_W'(SETTLE - 1);
            state_d = SETTLE_W;
         end
         SETTLE_W: begin
            if (tmr_q == '0) begin
               tmr_d   = TMR_W'(TIMEOUT - 1);
               state_d = REQ;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         REQ: begin
            // Ack is checked first so a late ack on the last allowed cycle
            // still counts as a good sample.
            if (sens_ack) begin
               t_ch_d[ch_q]    = sens_data;
               t_valid_d[ch_q] = 1'b1;
               fault_d[ch_q]   = 1'b0;
               state_d         = NEXT;
            end else if (tmr_q == '0) begin
               t_valid_d[ch_q] = 1'b0;
               fault_d[ch_q]   = 1'b1;
               state_d         = NEXT;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         default: begin
            ch_d    = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + CH_W'(1);
            state_d = SEL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= SEL;
         ch_q      <= '0;
         tmr_q     <= '0;
         t_valid_q <= '0;
         fault_q   <= '0;
         for (int k = 0; k < N_CH; k++) begin
            t_ch_q[k] <= '0;
         end
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         tmr_q     <= tmr_d;
         t_valid_q <= t_valid_d;
         fault_q   <= fault_d;
         t_ch_q    <= t_ch_d;
      end
   end

   assign sens_sel = 2'(ch_q);
   assign sens_req = (state_q == REQ);
   assign t_valid  = t_valid_q;
   assign fault    = fault_q;

   for (genvar k = 0; k < N_CH; k++) begin : g_tch
      assign t_ch[TEMP_W*k +: TEMP_W] = t_ch_q[k];
   end

   rr_heat_arbiter #(
      .N_CH     (N_CH),
      .MAX_HEAT (MAX_HEAT)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .ht_req  (ht_req),
      .t_valid (t_valid_q),
      .fault   (fault_q),
      .ht_gnt  (ht_gnt)
   );

endmodule
